// File: rtl/serial_sub_pkg.sv
// ---------------------------------------------------------------------------
// serial_sub_pkg
// Shared definitions for the bit-serial subtractor:
//   stateT           - controller states (IDLE, SHIFT, DONE)
//   DEFAULT_NUM_BITS - default operand/result width
// ---------------------------------------------------------------------------
package serial_sub_pkg;

  // Controller states. IDLE waits for start, SHIFT walks the operands one bit
  // per clock, DONE presents the finished result for a single cycle.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } stateT;

  localparam int DEFAULT_NUM_BITS = 4;

endpackage

// File: rtl/full_subtractor_1bit.sv
// ---------------------------------------------------------------------------
// full_subtractor_1bit
// Purely combinational one-bit subtract cell, used as the per-bit datapath of
// the serial subtractor.
// Ports:
//   a          in  minuend bit
//   b          in  subtrahend bit
//   borrow_in  in  borrow from the less significant bit
//   diff       out difference bit
//   borrow_out out borrow into the next more significant bit
// ---------------------------------------------------------------------------
module full_subtractor_1bit (
  input  logic a,
  input  logic b,
  input  logic borrow_in,
  output logic diff,
  output logic borrow_out
);

  // A borrow is generated when b exceeds a, and propagated when a and b are
  // equal and a borrow is already pending.
  assign diff       = a ^ b ^ borrow_in;
  assign borrow_out = (~a & b) | (~(a ^ b) & borrow_in);

endmodule

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
// Bit-serial subtractor computing (a - b - borrow_in) mod 2^NUM_BITS, LSB
// first, one bit per clock through a single full_subtractor_1bit cell.
// Ports:
//   clk        in  clock, all state updates on the rising edge
//   rst        in  synchronous active-high reset
//   start      in  begin a subtraction (accepted only in IDLE)
//   a, b       in  minuend / subtrahend, sampled with start
//   borrow_in  in  borrow into bit 0, sampled with start
//   busy       out high whenever the controller is not IDLE
//   done       out one-cycle pulse while the result is fresh
//   diff       out registered result
//   underflow  out registered final borrow out
// Configuration macro:
//   SERIAL_SUB_SATURATE_EN - when defined, diff is forced to zero whenever the
//                            subtraction underflows; underflow still reads 1.
// ---------------------------------------------------------------------------
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int NUM_BITS = DEFAULT_NUM_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [NUM_BITS-1:0] a,
  input  logic [NUM_BITS-1:0] b,
  input  logic                borrow_in,
  output logic                busy,
  output logic                done,
  output logic [NUM_BITS-1:0] diff,
  output logic                underflow
);

  localparam int COUNT_W = $clog2(NUM_BITS + 1);

  stateT               r_state;
  stateT               w_nextState;
  logic [NUM_BITS-1:0] r_shiftA;
  logic [NUM_BITS-1:0] r_shiftB;
  logic [NUM_BITS-1:0] r_diffShift;
  logic                r_borrow;
  logic [COUNT_W-1:0]  r_count;
  logic [NUM_BITS-1:0] r_diff;
  logic                r_underflow;
  logic                w_bitDiff;
  logic                w_bitBorrow;
  logic                w_lastBit;

  // The single subtract cell always looks at the current LSBs of the operand
  // shift registers and the running borrow.
  full_subtractor_1bit u_cell (
    .a          (r_shiftA[0]),
    .b          (r_shiftB[0]),
    .borrow_in  (r_borrow),
    .diff       (w_bitDiff),
    .borrow_out (w_bitBorrow)
  );

  // Once every bit has been shifted through the cell, the next SHIFT edge
  // publishes the assembled result and moves to DONE.
  assign w_lastBit = (r_count == COUNT_W'(NUM_BITS));

  // Next-state logic: start is only honoured from IDLE, and DONE always
  // falls back to IDLE so back-to-back requests need a fresh IDLE cycle.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (start) w_nextState = SHIFT;
      SHIFT:   if (w_lastBit) w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // State register; reset wins over any pending start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Datapath. Operands are captured on the accepting edge so later changes on
  // the inputs cannot disturb the operation. Difference bits are collected in
  // a private shift register and copied to the visible result only on the
  // edge entering DONE, so partial results never reach the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shiftA    <= '0;
      r_shiftB    <= '0;
      r_diffShift <= '0;
      r_borrow    <= 1'b0;
      r_count     <= '0;
      r_diff      <= '0;
      r_underflow <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_shiftA    <= a;
            r_shiftB    <= b;
            r_borrow    <= borrow_in;
            r_diffShift <= '0;
            r_count     <= '0;
          end
        end
        SHIFT: begin
          if (w_lastBit) begin
`ifdef SERIAL_SUB_SATURATE_EN
            r_diff <= r_borrow ? '0 : r_diffShift;
`else
            r_diff <= r_diffShift;
`endif
            r_underflow <= r_borrow;
          end else begin
            r_shiftA    <= r_shiftA >> 1;
            r_shiftB    <= r_shiftB >> 1;
            r_diffShift <= {w_bitDiff, r_diffShift[NUM_BITS-1:1]};
            r_borrow    <= w_bitBorrow;
            r_count     <= r_count + COUNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);
  assign diff      = r_diff;
  assign underflow = r_underflow;

endmodule
